bet_entry_controller: RTL

BET_ENTRY_CONTROLLER -- requirements
Module: bet_entry_controller

---
 rtl/bet_entry_controller.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bet_entry_controller.sv
// Bet entry controller: turns PS/2 scan bytes into bet-table writes, debits credits,
// launches wheel spins and credits payouts while a spin is in progress.
module bet_entry_controller #(
  parameter int          MAX_BETS      = 8,
  parameter logic [15:0] BET_UNIT      = 16'd1,
  parameter logic [15:0] START_BALANCE = 16'd100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [7:0]  key_data,
  output logic [7:0]  key_code,
  input  logic [7:0]  bet_opcode,
  input  logic        spin_done,
  input  logic        win_valid,
  input  logic [15:0] win_amount,
  output logic        bet_wr_en,
  output logic [2:0]  bet_wr_idx,
  output logic [5:0]  bet_wr_opcode,
  output logic [3:0]  bet_count,
  output logic [15:0] balance,
  output logic        spin_start,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_BETS);
  localparam logic [5:0] OP_NONE = 6'h3F;
  localparam logic [5:0] OP_SPIN = 6'h3E;
  localparam logic [7:0] KEY_BREAK  = 8'hF0;
  localparam logic [7:0] KEY_PREFIX = 8'hE0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BREAK     = 3'd1,
    S_LOOKUP    = 3'd2,
    S_DECODE    = 3'd3,
    S_SPIN_WAIT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  key_code_q, key_code_d;
  logic        wr_en_q, wr_en_d;
  logic [2:0]  wr_idx_q, wr_idx_d;
  logic [5:0]  wr_op_q, wr_op_d;
  logic [3:0]  count_q, count_d;
  logic [15:0] balance_q, balance_d;
  logic        spin_start_q, spin_start_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [16:0] win_sum_s;
  logic [5:0]  op_s;

  assign op_s      = bet_opcode[5:0];
  assign win_sum_s = {1'b0, balance_q} + {1'b0, win_amount};

  // Next-state and next-output logic for the key/bet/spin sequencer.
  always_comb begin
    state_d      = state_q;
    key_code_d   = key_code_q;
    wr_en_d      = 1'b0;
    wr_idx_d     = wr_idx_q;
    wr_op_d      = wr_op_q;
    count_d      = count_q;
    balance_d    = balance_q;
    spin_start_d = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          if (key_data == KEY_BREAK) begin
            state_d = S_BREAK;
          end else if (key_data == KEY_PREFIX) begin
            state_d = S_IDLE;
          end else begin
            key_code_d = key_data;
            state_d    = S_LOOKUP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BREAK: begin
        if (key_valid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      S_LOOKUP: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_IDLE;
        if (op_s == OP_NONE) begin
          err_d = 1'b0;
        end else if (op_s == OP_SPIN) begin
          if (count_q != 4'd0) begin
            spin_start_d = 1'b1;
            state_d      = S_SPIN_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end else if ((count_q >= MAX_CNT) || (balance_q < BET_UNIT)) begin
          err_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_idx_d  = count_q[2:0];
          wr_op_d   = op_s;
          count_d   = count_q + 4'd1;
          balance_d = balance_q - BET_UNIT;
        end
      end
      S_SPIN_WAIT: begin
        // Payout saturates rather than wrapping.
        if (win_valid) begin
          balance_d = win_sum_s[16] ? 16'hFFFF : win_sum_s[15:0];
        end else begin
          balance_d = balance_q;
        end
        if (spin_done) begin
          count_d = 4'd0;
          state_d = S_IDLE;
        end else begin
          state_d = S_SPIN_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      key_code_q   <= 8'h00;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= 3'd0;
      wr_op_q      <= 6'd0;
      count_q      <= 4'd0;
      balance_q    <= START_BALANCE;
      spin_start_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_code_q   <= key_code_d;
      wr_en_q      <= wr_en_d;
      wr_idx_q     <= wr_idx_d;
      wr_op_q      <= wr_op_d;
      count_q      <= count_d;
      balance_q    <= balance_d;
      spin_start_q <= spin_start_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign key_code      = key_code_q;
  assign bet_wr_en     = wr_en_q;
  assign bet_wr_idx    = wr_idx_q;
  assign bet_wr_opcode = wr_op_q;
  assign bet_count     = count_q;
  assign balance       = balance_q;
  assign spin_start    = spin_start_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule
